// File: rtl/counter_mod_updown.sv
// counter_mod_updown: modulo-MODULUS up/down counter with clear, clamped load, wrap pulse and cascade tc.
// Latency: count/wrap update one edge after the request, tc is combinational. Backpressure: none.
// Define COUNTER_SATURATE_EN to hold at the end of range instead of wrapping (wrap still pulses).
module counter_mod_updown #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("counter_mod_updown: MODULUS out of range for WIDTH");
    end
  endgenerate

  logic             end_step;
  logic [WIDTH-1:0] load_clamped;

  // End of range in the current direction; doubles as the cascade enable for the next stage.
  assign end_step = up ? (count == MAX_CNT) : (count == '0);
  assign tc       = end_step;

  // With MODULUS == 2^WIDTH no load_val can reach MOD_EXT, so the clamp never fires.
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (en) begin
      wrap <= end_step;
      if (end_step) begin
`ifdef COUNTER_SATURATE_EN
        count <= count;
`else
        count <= up ? '0 : MAX_CNT;
`endif
      end else begin
        count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
